// File: rtl/stereo_pair_splitter.sv
// Splits a side-by-side stereo line into aligned {left,right} pixel pairs.
// The left half is buffered in a line RAM and replayed against the live right half.
module stereo_pair_splitter #(
   parameter int HALF_IMG_WIDTH = 640,
   parameter int PIXEL_BITS     = 8,
   parameter int COL_WIDTH      = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  de_in,
   input  logic                  h_sync_in,
   input  logic                  v_sync_in,
   input  logic [PIXEL_BITS-1:0] pixel_in,
   output logic                  de_out,
   output logic                  h_sync_out,
   output logic                  v_sync_out,
   output logic [PIXEL_BITS-1:0] pixel_left,
   output logic [PIXEL_BITS-1:0] pixel_right,
   output logic                  line_err
);

   localparam int ADDR_W = (HALF_IMG_WIDTH > 1) ? $clog2(HALF_IMG_WIDTH) : 1;
   localparam logic [COL_WIDTH-1:0] HALF_C  = COL_WIDTH'(HALF_IMG_WIDTH);
   localparam logic [COL_WIDTH-1:0] LAST_L  = COL_WIDTH'(HALF_IMG_WIDTH - 1);
   localparam logic [COL_WIDTH-1:0] FULL_C  = COL_WIDTH'(2 * HALF_IMG_WIDTH);
   localparam logic [COL_WIDTH-1:0] LAST_R  = COL_WIDTH'(2 * HALF_IMG_WIDTH - 1);
   localparam logic [COL_WIDTH-1:0] COL_ONE = COL_WIDTH'(1);

   typedef enum logic [1:0] {WAIT_IDLE, LEFT, RIGHT, OVERRUN} state_t;

   state_t                 state_reg;
   logic [COL_WIDTH-1:0]   col_reg;
   logic                   over_reg;
   logic                   line_err_reg;

   logic [PIXEL_BITS-1:0]  line_ram [HALF_IMG_WIDTH];

   logic                   line_end;
   logic                   wr_en;
   logic                   rd_hit;
   logic [ADDR_W-1:0]      wr_addr;
   logic [ADDR_W-1:0]      rd_addr;

   logic                   pair_s1_reg;
   logic [ADDR_W-1:0]      rd_addr_s1_reg;
   logic [PIXEL_BITS-1:0]  pix_s1_reg;
   logic                   hs_s1_reg;
   logic                   vs_s1_reg;

   logic                   de_out_reg;
   logic                   hs_out_reg;
   logic                   vs_out_reg;
   logic [PIXEL_BITS-1:0]  pixel_left_reg;
   logic [PIXEL_BITS-1:0]  pixel_right_reg;

   // A nonzero column with de_in low means the previous cycle was the last pixel.
   always_comb begin
      line_end = !de_in && (col_reg != '0);
      wr_en    = (state_reg == LEFT) && de_in && (col_reg < HALF_C);
      rd_hit   = (state_reg == RIGHT) && de_in;
      wr_addr  = ADDR_W'(col_reg);
      rd_addr  = ADDR_W'(col_reg - HALF_C);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= WAIT_IDLE;
         col_reg      <= '0;
         over_reg     <= 1'b0;
         line_err_reg <= 1'b0;
      end else begin
         // over_reg marks pixels beyond the saturated counter so overruns still flag.
         line_err_reg <= line_end && (state_reg != WAIT_IDLE) &&
                         ((col_reg != FULL_C) || over_reg);

         if (!de_in) begin
            col_reg  <= '0;
            over_reg <= 1'b0;
         end else if (col_reg == FULL_C) begin
            over_reg <= 1'b1;
         end else begin
            col_reg  <= col_reg + COL_ONE;
         end

         case (state_reg)
            WAIT_IDLE: if (!de_in) state_reg <= LEFT;
            LEFT: begin
               if (de_in && (col_reg == LAST_L)) state_reg <= RIGHT;
            end
            RIGHT: begin
               if (!de_in)                    state_reg <= LEFT;
               else if (col_reg == LAST_R)    state_reg <= OVERRUN;
            end
            OVERRUN: if (!de_in) state_reg <= LEFT;
            default: state_reg <= WAIT_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) line_ram[wr_addr] <= pixel_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pair_s1_reg    <= 1'b0;
         rd_addr_s1_reg <= '0;
         pix_s1_reg     <= '0;
         hs_s1_reg      <= 1'b0;
         vs_s1_reg      <= 1'b0;
      end else begin
         pair_s1_reg    <= rd_hit;
         rd_addr_s1_reg <= rd_addr;
         pix_s1_reg     <= pixel_in;
         hs_s1_reg      <= h_sync_in;
         vs_s1_reg      <= v_sync_in;
      end
   end

   // Pixel outputs only move on a valid pair so they hold while de_out is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_out_reg      <= 1'b0;
         hs_out_reg      <= 1'b0;
         vs_out_reg      <= 1'b0;
         pixel_left_reg  <= '0;
         pixel_right_reg <= '0;
      end else begin
         de_out_reg <= pair_s1_reg;
         hs_out_reg <= hs_s1_reg;
         vs_out_reg <= vs_s1_reg;
         if (pair_s1_reg) begin
            pixel_left_reg  <= line_ram[rd_addr_s1_reg];
            pixel_right_reg <= pix_s1_reg;
         end
      end
   end

   assign de_out      = de_out_reg;
   assign h_sync_out  = hs_out_reg;
   assign v_sync_out  = vs_out_reg;
   assign pixel_left  = pixel_left_reg;
   assign pixel_right = pixel_right_reg;
   assign line_err    = line_err_reg;

endmodule
